// File: rtl/mac_dual_array.sv
// Dual-weight MAC lane array: each lane multiplies a shared data operand by two
// weights, accumulates both products per batch and emits one result per batch.
module mac_dual_array #(
  parameter int N  = 144,
  parameter int WW = 8,
  parameter int DW = 4,
  parameter int AW = 24,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_signed,
  input  logic [WW*N-1:0] weight1,
  input  logic [WW*N-1:0] weight2,
  input  logic [DW*N-1:0] data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW*N-1:0] acc_out1,
  output logic [AW*N-1:0] acc_out2,
  output logic [CW-1:0]   out_beats,
  output logic            out_ovf
);
  localparam logic [CW-1:0] BEATS_MAX = '1;
  localparam logic [CW-1:0] BEATS_ONE = CW'(1);

  // Product is formed directly at accumulator width so sign/zero extension is implicit.
  function automatic logic [AW-1:0] lane_mul(input logic [WW-1:0] w, input logic [DW-1:0] d,
                                             input logic sgn);
    logic signed [AW-1:0] we;
    logic signed [AW-1:0] de;
    if (sgn) begin
      we = AW'($signed(w));
      de = AW'($signed(d));
    end else begin
      we = AW'(w);
      de = AW'(d);
    end
    return AW'(we * de);
  endfunction

  // Returns {saturated, result}.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                          input logic sgn);
    logic [AW:0]   sum;
    logic          ovf;
    logic [AW-1:0] lim;
    if (sgn) begin
      sum = {a[AW-1], a} + {b[AW-1], b};
      ovf = sum[AW] ^ sum[AW-1];
      lim = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
      ovf = sum[AW];
      lim = '1;
    end
    return {ovf, ovf ? lim : sum[AW-1:0]};
  endfunction

  logic            adv;
  logic            accept;
  logic            mode_q;
  logic            mode_cur;
  logic [AW*N-1:0] p1_d;
  logic [AW*N-1:0] p2_d;
  logic [AW*N-1:0] p1_q;
  logic [AW*N-1:0] p2_q;
  logic            p_valid;
  logic            p_first;
  logic            p_last;
  logic            p_sgn;
  logic [AW*N-1:0] acc1_q;
  logic [AW*N-1:0] acc2_q;
  logic [AW*N-1:0] acc1_n;
  logic [AW*N-1:0] acc2_n;
  logic [CW-1:0]   beats_q;
  logic [CW-1:0]   beats_n;
  logic            ovf_q;
  logic            ovf_n;
  logic            open_q;
  logic            restart;
  logic            sat1;
  logic            sat2;
  logic            sat_any;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign mode_cur = in_first ? in_signed : mode_q;
  // A beat after a last beat opens a fresh batch even without in_first.
  assign restart  = p_first || !open_q;

  always_comb begin
    p1_d = '0;
    p2_d = '0;
    for (int i = 0; i < N; i++) begin
      p1_d[AW*i +: AW] = lane_mul(weight1[WW*i +: WW], data[DW*i +: DW], mode_cur);
      p2_d[AW*i +: AW] = lane_mul(weight2[WW*i +: WW], data[DW*i +: DW], mode_cur);
    end
  end

  always_comb begin
    acc1_n  = p1_q;
    acc2_n  = p2_q;
    sat1    = 1'b0;
    sat2    = 1'b0;
    sat_any = 1'b0;
    if (!restart) begin
      for (int i = 0; i < N; i++) begin
        {sat1, acc1_n[AW*i +: AW]} = sat_add(acc1_q[AW*i +: AW], p1_q[AW*i +: AW], p_sgn);
        {sat2, acc2_n[AW*i +: AW]} = sat_add(acc2_q[AW*i +: AW], p2_q[AW*i +: AW], p_sgn);
        sat_any = sat_any | sat1 | sat2;
      end
    end
    beats_n = restart ? BEATS_ONE :
              (beats_q == BEATS_MAX) ? BEATS_MAX : beats_q + BEATS_ONE;
    ovf_n   = !restart && (ovf_q || sat_any);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      p_valid   <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      p_sgn     <= 1'b0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      beats_q   <= '0;
      ovf_q     <= 1'b0;
      open_q    <= 1'b0;
      out_valid <= 1'b0;
      acc_out1  <= '0;
      acc_out2  <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      p_valid <= in_valid;
      if (accept) begin
        p1_q    <= p1_d;
        p2_q    <= p2_d;
        p_first <= in_first;
        p_last  <= in_last;
        p_sgn   <= mode_cur;
        if (in_first) mode_q <= in_signed;
      end
      if (p_valid) begin
        acc1_q  <= acc1_n;
        acc2_q  <= acc2_n;
        beats_q <= beats_n;
        ovf_q   <= ovf_n;
        open_q  <= !p_last;
      end
      // adv high with out_valid set implies out_ready, so the old result has left.
      out_valid <= p_valid && p_last;
      if (p_valid && p_last) begin
        acc_out1  <= acc1_n;
        acc_out2  <= acc2_n;
        out_beats <= beats_n;
        out_ovf   <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_mac_dual_array.sv
// Bench for mac_dual_array: two builds (wide accumulator, narrow 12-bit/3-bit-count)
// share stimulus and are checked against an arithmetic batch model.
module tb_mac_dual_array;
  localparam int N   = 4;
  localparam int WW  = 8;
  localparam int DW  = 4;
  localparam int AW0 = 24;
  localparam int AW1 = 12;
  localparam int CW0 = 16;
  localparam int CW1 = 3;

  typedef struct packed {
    logic [95:0] a1;
    logic [95:0] a2;
    logic [15:0] beats;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic in_last = 1'b0;
  logic in_signed = 1'b0;
  logic out_ready = 1'b1;
  logic [WW*N-1:0] weight1 = '0;
  logic [WW*N-1:0] weight2 = '0;
  logic [DW*N-1:0] data = '0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [AW0*N-1:0] a1_0, a2_0;
  logic [AW1*N-1:0] a1_1, a2_1;
  logic [CW0-1:0] beats0;
  logic [CW1-1:0] beats1;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int hs_cyc[$];
  res_t q0[$];
  res_t q1[$];

  longint m_acc[2][N][2];
  int     m_beats[2];
  bit     m_ovf[2];
  bit     m_open = 1'b0;
  bit     m_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dual_array #(.N(N), .WW(WW), .DW(DW), .AW(AW0), .CW(CW0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_first(in_first), .in_last(in_last), .in_signed(in_signed),
    .weight1(weight1), .weight2(weight2), .data(data),
    .out_valid(out_valid0), .out_ready(out_ready), .acc_out1(a1_0), .acc_out2(a2_0),
    .out_beats(beats0), .out_ovf(ovf0));

  mac_dual_array #(.N(N), .WW(WW), .DW(DW), .AW(AW1), .CW(CW1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_first(in_first), .in_last(in_last), .in_signed(in_signed),
    .weight1(weight1), .weight2(weight2), .data(data),
    .out_valid(out_valid1), .out_ready(out_ready), .acc_out1(a1_1), .acc_out2(a2_1),
    .out_beats(beats1), .out_ovf(ovf1));

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: no response within cycle budget", name);
  endfunction

  function automatic longint v8(input logic [7:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint v4(input logic [3:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Batch arithmetic straight from the rules: products, clamped running sums, beat counts.
  task automatic model_beat();
    bit restart, md;
    longint p, s, lo, hi;
    res_t r0, r1;
    restart = in_first || !m_open;
    md = in_first ? in_signed : m_mode;
    if (in_first) m_mode = in_signed;
    for (int k = 0; k < 2; k++) begin
      int aw;
      int cmax;
      aw   = k ? AW1 : AW0;
      cmax = k ? 7 : 65535;
      lo = md ? -(longint'(1) <<< (aw - 1)) : longint'(0);
      hi = md ? (longint'(1) <<< (aw - 1)) - 1 : (longint'(1) <<< aw) - 1;
      if (restart) begin
        m_beats[k] = 1;
        m_ovf[k] = 1'b0;
      end else if (m_beats[k] < cmax) begin
        m_beats[k]++;
      end
      for (int i = 0; i < N; i++) begin
        for (int b = 0; b < 2; b++) begin
          p = v8(b ? weight2[WW*i +: WW] : weight1[WW*i +: WW], md) * v4(data[DW*i +: DW], md);
          if (restart) s = p;
          else begin
            s = m_acc[k][i][b] + p;
            if (s > hi) begin s = hi; m_ovf[k] = 1'b1; end
            if (s < lo) begin s = lo; m_ovf[k] = 1'b1; end
          end
          m_acc[k][i][b] = s;
        end
      end
    end
    m_open = !in_last;
    if (in_last) begin
      r0 = '0;
      r1 = '0;
      for (int i = 0; i < N; i++) begin
        r0.a1[AW0*i +: AW0] = AW0'(m_acc[0][i][0]);
        r0.a2[AW0*i +: AW0] = AW0'(m_acc[0][i][1]);
        r1.a1[AW1*i +: AW1] = AW1'(m_acc[1][i][0]);
        r1.a2[AW1*i +: AW1] = AW1'(m_acc[1][i][1]);
      end
      r0.beats = 16'(m_beats[0]);
      r0.ovf   = m_ovf[0];
      r1.beats = 16'(m_beats[1]);
      r1.ovf   = m_ovf[1];
      q0.push_back(r0);
      q1.push_back(r1);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_open = 1'b0;
    m_mode = 1'b0;
  endtask

  // Lane i gets w + 13*step*i and d + 5*step*i so lanes differ when step is nonzero.
  task automatic beat(input bit f, input bit l, input bit s, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [3:0] d, input int step);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_first = f;
    in_last = l;
    in_signed = s;
    for (int i = 0; i < N; i++) begin
      weight1[WW*i +: WW] = w1 + 8'(13 * step * i);
      weight2[WW*i +: WW] = w2 + 8'(13 * step * i);
      data[DW*i +: DW]    = d + 4'(5 * step * i);
    end
    n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!in_ready0) begin
      n++;
      if (n > 50) begin
        timeout("in_ready_wait");
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (ok) model_beat();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid0) begin
      n++;
      if (n > 20) begin
        timeout(name);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: handshake rule every cycle, result contents whenever out_valid is high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready0, !(out_valid0 && !out_ready));
        chk("in_ready_narrow", in_ready1, in_ready0);
        chk("out_valid_narrow", out_valid1, out_valid0);
        if (out_valid0) begin
          if (q0.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result_wide: out_valid=1, required no pending result");
          end else begin
            chk("acc_out1_wide", a1_0, q0[0].a1);
            chk("acc_out2_wide", a2_0, q0[0].a2);
            chk("out_beats_wide", beats0, q0[0].beats);
            chk("out_ovf_wide", ovf0, q0[0].ovf);
            if (out_ready) begin
              void'(q0.pop_front());
              hs_cyc.push_back(cyc);
            end
          end
        end
        if (out_valid1) begin
          if (q1.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result_narrow: out_valid=1, required no pending result");
          end else begin
            chk("acc_out1_narrow", a1_1, q1[0].a1);
            chk("acc_out2_narrow", a2_1, q1[0].a2);
            chk("out_beats_narrow", beats1, q1[0].beats);
            chk("out_ovf_narrow", ovf1, q1[0].ovf);
            if (out_ready) void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_acc_out1", a1_0, '0);
    chk("rst_acc_out2_narrow", a2_1, '0);
    chk("rst_out_beats", beats0, '0);
    chk("rst_out_ovf", ovf0, 1'b0);
    idle(1);

    // single-beat unsigned batch
    beat(1, 1, 0, 8'd3, 8'd5, 4'd7, 0);
    wait_valid("t1_wait");
    chk("t1_acc1", a1_0, {N{24'd21}});
    chk("t1_acc2", a2_0, {N{24'd35}});
    chk("t1_beats", beats0, 16'd1);
    chk("t1_ovf", ovf0, 1'b0);
    idle(3);

    // signed 4-beat batch: wide build exact, narrow build clamps
    beat(1, 0, 1, 8'h80, 8'h7F, 4'h8, 0);
    beat(0, 0, 0, 8'h80, 8'h7F, 4'h8, 0);
    beat(0, 0, 0, 8'h80, 8'h7F, 4'h8, 0);
    beat(0, 1, 0, 8'h80, 8'h7F, 4'h8, 0);
    wait_valid("t2_wait");
    chk("t2_acc1", a1_0[23:0], 24'd4096);
    chk("t2_acc2", a2_0[23:0], 24'hFFF020);
    chk("t2_beats", beats0, 16'd4);
    chk("t2_ovf", ovf0, 1'b0);
    chk("t2_acc1_narrow", a1_1[11:0], 12'h7FF);
    chk("t2_acc2_narrow", a2_1[11:0], 12'h800);
    chk("t2_ovf_narrow", ovf1, 1'b1);
    idle(3);

    // unsigned clamp on the 12-bit build
    beat(1, 0, 0, 8'd255, 8'd255, 4'd15, 0);
    beat(0, 1, 1, 8'd255, 8'd255, 4'd15, 0);
    wait_valid("t3_wait");
    chk("t3_acc_narrow", a1_1[11:0], 12'hFFF);
    chk("t3_ovf_narrow", ovf1, 1'b1);
    chk("t3_acc_wide", a1_0[23:0], 24'd7650);
    chk("t3_ovf_wide", ovf0, 1'b0);
    idle(3);

    // back-to-back single-beat batches, lanes varied, mixed modes
    base = hs_cyc.size();
    for (int k = 0; k < 6; k++)
      beat(1, 1, k[0], 8'(k * 37 + 1), 8'(200 - k * 29), 4'(k * 3 + 1), 1);
    idle(6);
    if (hs_cyc.size() < base + 6) timeout("t4_results");
    else chk("t4_no_bubble", hs_cyc[base+5] - hs_cyc[base], 5);

    // downstream stall with several results in flight
    out_ready = 1'b0;
    fork
      begin
        beat(1, 1, 0, 8'd11, 8'd22, 4'd3, 1);
        beat(1, 1, 1, 8'hF0, 8'h0F, 4'h9, 1);
        beat(1, 1, 0, 8'd4, 8'd5, 4'd6, 1);
        beat(1, 1, 0, 8'd7, 8'd8, 4'd9, 1);
      end
      begin
        wait_valid("t5_wait");
        repeat (5) begin
          @(negedge clk);
          chk("t5_in_ready", in_ready0, 1'b0);
          chk("t5_out_valid", out_valid0, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);

    // in_first mid-batch discards the open batch
    beat(1, 0, 0, 8'd10, 8'd10, 4'd1, 0);
    beat(1, 1, 0, 8'd1, 8'd2, 4'd3, 0);
    wait_valid("t7_wait");
    chk("t7_acc1", a1_0[23:0], 24'd3);
    chk("t7_acc2", a2_0[23:0], 24'd6);
    chk("t7_beats", beats0, 16'd1);
    idle(3);

    // 9-beat batch: 3-bit beat counter saturates at 7
    beat(1, 0, 0, 8'd1, 8'd2, 4'd1, 1);
    for (int k = 0; k < 7; k++) beat(0, 0, 0, 8'(k + 2), 8'd3, 4'd2, 1);
    beat(0, 1, 0, 8'd5, 8'd6, 4'd3, 1);
    wait_valid("t8_wait");
    chk("t8_beats_wide", beats0, 16'd9);
    chk("t8_beats_narrow", beats1, 3'd7);
    idle(3);

    // reset mid-batch, then a fresh batch
    beat(1, 0, 0, 8'd9, 8'd9, 4'd9, 0);
    beat(0, 0, 0, 8'd9, 8'd9, 4'd9, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t6_rst_out_valid", out_valid0, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(1, 1, 0, 8'd2, 8'd3, 4'd4, 0);
    wait_valid("t6_wait");
    chk("t6_acc1", a1_0, {N{24'd8}});
    chk("t6_acc2", a2_0, {N{24'd12}});
    chk("t6_beats", beats0, 16'd1);
    idle(5);

    chk("drain_wide", q0.size(), 0);
    chk("drain_narrow", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mac_dual_array.md
Name: mac_dual_array

Overview:
- Parametrised successor to the packed dual-multiply lane array.
- Each of N lanes multiplies one shared data operand by two independent weights and accumulates both products across a batch of beats.
- Every stage is registered, with valid/ready handshakes on both sides and a selectable signed or unsigned mode.
- Sits between the weight/activation buffers and the post-processing (requant) stage; one output beat per batch.

Parameters:
- N, 144, number of parallel lanes
- WW, 8, weight width per lane
- DW, 4, data width per lane
- AW, 24, accumulator width per lane and product; AW >= WW+DW+1
- CW, 16, batch beat-counter width

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, input beat valid
- in_ready, output, 1, input beat accepted when in_valid && in_ready
- in_first, input, 1, beat starts a new batch; accumulators are loaded, not added
- in_last, input, 1, beat ends the batch; result is emitted
- in_signed, input, 1, sampled on the first beat: 1 = both operands two's complement, 0 = both unsigned
- weight1, input, WW*N, lane i weight uses bits [WW*i +: WW]
- weight2, input, WW*N, second weight bank, same slicing
- data, input, DW*N, lane i data uses bits [DW*i +: DW]
- out_valid, output, 1, result beat valid
- out_ready, input, 1, downstream accepts result
- acc_out1, output, AW*N, lane i result at [AW*i +: AW]
- acc_out2, output, AW*N, second-bank results, same slicing
- out_beats, output, CW, number of beats in the emitted batch; saturates at 2^CW-1
- out_ovf, output, 1, at least one lane/bank saturated during the batch

Behaviour:
- Reset, asynchronous on rst_n low:
  - all valids, accumulators, output registers, out_beats and out_ovf = 0
  - mode register = 0 (unsigned)
  - in_ready = 1 once reset is released
- Global stall:
  - adv = !(out_valid && !out_ready)
  - in_ready = adv
  - all stages hold when adv = 0
- Stage 1 (P), on accept:
  - p1[i] = weight1_i*data_i and p2[i] = weight2_i*data_i, each WW+DW bits, sign- or zero-extended to AW per mode
  - registers valid, first, last
  - mode is taken from in_signed if in_first, else from the latched mode register
- Stage 2 (A), when P valid and adv:
  - if first, or the previous beat was last (no open batch): acc = p; beats = 1; ovf = 0
  - else: acc = sat(acc + p); beats = min(beats+1, max); ovf |= any saturation
- Saturation:
  - signed: clamp to [-2^(AW-1), 2^(AW-1)-1]
  - unsigned: clamp to 2^AW-1
- Emit:
  - if the P beat is last, the final acc/beats/ovf values are copied into the output registers and out_valid = 1
  - the accumulators are free the next cycle, so a new batch streams with no bubble
- Output clear: out_valid drops after an out_valid && out_ready cycle unless a new last beat lands in the same cycle, in which case out_valid stays 1 with the new data.
- Latency: last beat accepted at cycle t gives out_valid at t+2 (no stall).
- Throughput: 1 beat/cycle while out_ready = 1.
- Single-beat batch (first && last): result = p, beats = 1.
- in_first mid-batch: the open batch is discarded without emit; accumulation restarts.
- Output registers hold stable while out_valid && !out_ready.
- rst_n low mid-batch: all state is lost immediately; no partial output.

Test Plan:
- Reset, then a single-beat batch (first, last), unsigned, all lanes w1=3, w2=5, d=7 -> at t+2 every lane shows acc1=21, acc2=35, beats=1, ovf=0.
- Signed, 4-beat batch with w1=-128, w2=127, d=-8 (lane 0) -> acc1=4096, acc2=-4064, beats=4.
- Unsigned, AW=12 build, w=255, d=15 for 2 beats -> acc clamps to 4095, out_ovf=1.
- Back-to-back batches of 1 beat with out_ready=1 -> one result per cycle, no bubbles, values match each beat.
- Hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, outputs unchanged; release -> the stream resumes with no lost or duplicated beat.
- Assert rst_n low mid-batch, then release and run a new first beat -> out_valid=0 throughout reset, and the new result excludes the old beats.
